// File: rtl/dw_batch_grad_if.sv
// Operand and result streams of the delta-weight generator.
// The block itself connects through the slave modport.
interface dw_batch_grad_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_IN   = 4
);
  localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_layer;
  logic [DATA_W-1:0] delta;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;

  modport master (
    output in_valid, in_layer, delta, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_layer, delta, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/dw_batch_grad.sv
// Delta-weight generator: dW[i] = 2^-LR_SHIFT * sum(in_layer[i] * delta) over a batch,
// using one time-shared multiplier and per-channel accumulators.
module dw_batch_grad #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 10,
  parameter int unsigned N_IN     = 4,
  parameter int unsigned LR_SHIFT = 5,
  parameter int unsigned BATCH_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BATCH_W-1:0] batch_len,
  dw_batch_grad_if.slave     strm,
  output logic               busy,
  output logic               done
);
  localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W = PROD_W + BATCH_W;
  localparam int unsigned SHIFT = FRAC_W + LR_SHIFT;

  localparam logic [IDX_W-1:0] LastCh = IDX_W'(N_IN - 1);
  localparam logic signed [ACC_W:0] RoundK = (ACC_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W:0] MaxV = (ACC_W + 1)'((64'd1 << (DATA_W - 1)) - 64'd1);
  localparam logic signed [ACC_W:0] MinV = -MaxV - (ACC_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]        ch_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BATCH_W-1:0]      smp_q;
  logic [BATCH_W-1:0]      len_q;
  logic                    done_q;
  logic signed [ACC_W-1:0] acc_q [N_IN];

  logic                     beat;
  logic                     last_beat;
  logic                     out_hs;
  logic                     last_out;
  logic [BATCH_W-1:0]       eff_len;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sel;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    shf;
  logic [DATA_W-1:0]        sat;

  assign beat      = (state_q == StAccum) && strm.in_valid;
  assign last_beat = beat && (ch_q == LastCh) && (smp_q == len_q - BATCH_W'(1));
  assign out_hs    = (state_q == StEmit) && strm.out_ready;
  assign last_out  = out_hs && (idx_q == LastCh);
  assign eff_len   = (batch_len == '0) ? BATCH_W'(1) : batch_len;

  assign prod     = $signed(strm.in_layer) * $signed(strm.delta);
  assign prod_ext = {{BATCH_W{prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start)     state_d = StAccum;
      StAccum: if (last_beat) state_d = StEmit;
      StEmit:  if (last_out)  state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q   <= '0;
      idx_q  <= '0;
      smp_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < N_IN; i++) acc_q[i] <= '0;
    end else begin
      done_q <= last_out;
      if ((state_q == StIdle) && start) begin
        for (int i = 0; i < N_IN; i++) acc_q[i] <= '0;
        len_q <= eff_len;
        ch_q  <= '0;
        smp_q <= '0;
        idx_q <= '0;
      end
      if (beat) begin
        acc_q[ch_q] <= acc_q[ch_q] + prod_ext;
        if (ch_q == LastCh) begin
          ch_q  <= '0;
          smp_q <= smp_q + BATCH_W'(1);
        end else begin
          ch_q <= ch_q + IDX_W'(1);
        end
      end
      if (out_hs) begin
        idx_q <= last_out ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Round half up, then arithmetic shift; one guard bit keeps the rounding add from wrapping.
  always_comb begin
    acc_sel = acc_q[idx_q];
    rnd     = {acc_sel[ACC_W-1], acc_sel} + RoundK;
    shf     = rnd >>> SHIFT;
    sat     = shf[DATA_W-1:0];
    if (shf > MaxV) begin
      sat = MaxV[DATA_W-1:0];
    end else if (shf < MinV) begin
      sat = MinV[DATA_W-1:0];
    end
  end

  assign strm.in_ready  = (state_q == StAccum);
  assign strm.out_valid = (state_q == StEmit);
  assign strm.out_data  = sat;
  assign strm.out_idx   = idx_q;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
endmodule

// File: tb/tb_dw_batch_grad.sv
// Self-checking bench for dw_batch_grad: directed and random batches compared against a
// plain-arithmetic model of the scaled batch sums.
module tb_dw_batch_grad;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FRAC_W   = 10;
  localparam int unsigned N_IN     = 4;
  localparam int unsigned LR_SHIFT = 5;
  localparam int unsigned BATCH_W  = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [BATCH_W-1:0] batch_len = '0;
  logic               busy;
  logic               done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] lay [16][N_IN];
  logic [15:0] dl  [16];

  dw_batch_grad_if #(.DATA_W(DATA_W), .N_IN(N_IN)) bus ();

  dw_batch_grad #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .N_IN    (N_IN),
    .LR_SHIFT(LR_SHIFT),
    .BATCH_W (BATCH_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .batch_len(batch_len),
    .strm     (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // dW = floor((sum + half) / 2^shift), clipped to the signed output range
  function automatic logic [15:0] model_dw(input int ch, input int len);
    longint s = 0;
    longint r;
    longint sh = FRAC_W + LR_SHIFT;
    for (int k = 0; k < len; k++) begin
      s += longint'($signed(lay[k][ch])) * longint'($signed(dl[k]));
    end
    r = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic fill_const(input logic [15:0] l, input logic [15:0] d);
    for (int k = 0; k < 16; k++) begin
      dl[k] = d;
      for (int c = 0; c < N_IN; c++) lay[k][c] = l;
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 16; k++) begin
      dl[k] = 16'($urandom);
      for (int c = 0; c < N_IN; c++) lay[k][c] = 16'($urandom);
    end
  endtask

  task automatic run_batch(input int len_field, input bit gaps, input int stall_at);
    int len;
    logic [15:0] hold_data;
    len = (len_field == 0) ? 1 : len_field;
    @(negedge clk);
    // junk beat while idle must be dropped
    bus.in_valid = 1'b1;
    bus.in_layer = 16'h7fff;
    bus.delta    = 16'h7fff;
    start        = 1'b1;
    batch_len    = 4'(len_field);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    for (int s = 0; s < len; s++) begin
      for (int c = 0; c < N_IN; c++) begin
        if (gaps) begin
          while ($urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_layer = 16'($urandom);
            bus.delta    = 16'($urandom);
            @(negedge clk);
          end
        end
        bus.in_valid = 1'b1;
        bus.in_layer = lay[s][c];
        bus.delta    = dl[s];
        check("in_ready_accum", bus.in_ready, 1'b1);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    check("out_valid_latency", bus.out_valid, 1'b1);
    check("in_ready_drop", bus.in_ready, 1'b0);
    for (int c = 0; c < N_IN; c++) begin
      if (c == stall_at) begin
        bus.out_ready = 1'b0;
        hold_data = bus.out_data;
        for (int t = 0; t < 5; t++) begin
          start        = (t == 0);
          bus.in_valid = 1'b1;
          @(negedge clk);
          start        = 1'b0;
          bus.in_valid = 1'b0;
          check("stall_idx", bus.out_idx, c);
          check("stall_data", bus.out_data, hold_data);
          check("stall_no_done", done, 1'b0);
          check("stall_valid", bus.out_valid, 1'b1);
        end
      end else if (gaps) begin
        bus.out_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.out_ready = 1'b1;
      check("out_valid", bus.out_valid, 1'b1);
      check("out_idx", bus.out_idx, c);
      check("out_data", bus.out_data, model_dw(c, len));
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("done_pulse", done, 1'b1);
    check("out_valid_end", bus.out_valid, 1'b0);
    check("busy_end", busy, 1'b0);
    @(negedge clk);
    check("done_single", done, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_layer  = '0;
    bus.delta     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 16'h0000);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    fill_const(16'h1000, 16'h1000);
    run_batch(1, 1'b0, -1);
    fill_const(16'hf000, 16'hf000);
    run_batch(1, 1'b0, 2);
    fill_const(16'h1000, 16'hf000);
    run_batch(0, 1'b0, -1);

    fill_const(16'h1000, 16'h1000);
    dl[1] = 16'hf000;
    run_batch(2, 1'b0, -1);
    run_batch(2, 1'b1, -1);

    fill_const(16'h0010, 16'h0400);
    run_batch(1, 1'b0, -1);
    fill_const(16'h000f, 16'h0400);
    run_batch(1, 1'b0, -1);
    fill_const(16'hffe0, 16'h0400);
    run_batch(1, 1'b0, -1);

    fill_const(16'h7c00, 16'h7c00);
    run_batch(15, 1'b0, -1);
    fill_const(16'h7c00, 16'h8400);
    run_batch(15, 1'b1, -1);

    // reset in the middle of accumulation
    fill_const(16'h1000, 16'h1000);
    @(negedge clk);
    start     = 1'b1;
    batch_len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_layer = 16'h1000;
    bus.delta    = 16'h1000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_data", bus.out_data, 16'h0000);
    check("midrst_out_idx", bus.out_idx, 0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    rst = 1'b0;

    for (int r = 0; r < 6; r++) begin
      fill_rand();
      run_batch(int'($urandom_range(0, 15)), 1'b1, (r == 3) ? 1 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
